// File: rtl/awg_param_ctrl.sv
// rtl/awg_param_ctrl.sv - front-panel key handling and shared generator parameter registers
module awg_param_ctrl #(
  parameter logic [19:0] DEB_CYCLES    = 20'd500000,
  parameter logic [24:0] HOLD_CYCLES   = 25'd25000000,
  parameter logic [22:0] REPEAT_CYCLES = 23'd5000000,
  parameter logic [11:0] FREQ_RESET    = 12'd64,
  parameter logic [11:0] FREQ_STEP     = 12'd16,
  parameter logic [7:0]  PHASE_STEP    = 8'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  key_n,
  output logic [11:0] state_freq,
  output logic [2:0]  state_amp,
  output logic [7:0]  state_phase,
  output logic        en_sqr,
  output logic        en_sin,
  output logic        en_tri,
  output logic        en_saw,
  output logic        param_upd
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } key_state_e;

  // Keys 0 (freq up), 1 (freq down) and 3 (phase) auto-repeat; amp and wave do not.
  localparam logic [4:0]  REPEAT_KEYS = 5'b01011;
  localparam logic [19:0] DEB_LAST    = DEB_CYCLES - 20'd1;
  localparam logic [24:0] HOLD_LAST   = HOLD_CYCLES - 25'd1;
  localparam logic [24:0] REP_LAST    = {2'b00, REPEAT_CYCLES - 23'd1};

  // Synchroniser stores the inverted pin, so a cleared flop reads as "released".
  logic [4:0]  meta_q, meta_d;
  logic [4:0]  sync_q, sync_d;
  logic [4:0]  acc_q, acc_d;
  logic [19:0] deb_cnt_q [5];
  logic [19:0] deb_cnt_d [5];
  key_state_e  state_q [5];
  key_state_e  state_d [5];
  logic [24:0] tmr_q [5];
  logic [24:0] tmr_d [5];
  logic [4:0]  strobe_q, strobe_d;

  logic [11:0] freq_q, freq_d;
  logic [2:0]  amp_q, amp_d;
  logic [7:0]  phase_q, phase_d;
  logic [3:0]  en_q, en_d;       // {saw, tri, sqr, sin}
  logic        chg_q, chg_d;     // an output changed on the last edge
  logic        param_upd_q, param_upd_d;
  logic [12:0] freq_sum;

  // Two-stage synchroniser on the active-high pressed level.
  always_comb begin
    meta_d = ~key_n;
    sync_d = meta_q;
  end

  // Debounce: count while the synchronised level disagrees with the accepted one.
  always_comb begin
    acc_d = acc_q;
    for (int k = 0; k < 5; k++) begin
      deb_cnt_d[k] = 20'd0;
      if (sync_q[k] != acc_q[k]) begin
        if (deb_cnt_q[k] == DEB_LAST) begin
          acc_d[k] = sync_q[k];
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + 20'd1;
        end
      end
    end
  end

  // Per-key IDLE/HOLD/REPEAT machine; one shared timer serves as hold and repeat counter.
  always_comb begin
    strobe_d = 5'b0;
    for (int k = 0; k < 5; k++) begin
      state_d[k] = state_q[k];
      tmr_d[k]   = tmr_q[k];
      case (state_q[k])
        ST_IDLE: begin
          if (acc_q[k]) begin
            state_d[k]  = ST_HOLD;
            tmr_d[k]    = 25'd0;
            strobe_d[k] = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!acc_q[k]) begin
            state_d[k] = ST_IDLE;
          end else if (REPEAT_KEYS[k]) begin
            if (tmr_q[k] == HOLD_LAST) begin
              state_d[k]  = ST_REPEAT;
              tmr_d[k]    = 25'd0;
              strobe_d[k] = 1'b1;
            end else begin
              tmr_d[k] = tmr_q[k] + 25'd1;
            end
          end
        end
        ST_REPEAT: begin
          if (!acc_q[k]) begin
            state_d[k] = ST_IDLE;
          end else if (tmr_q[k] == REP_LAST) begin
            tmr_d[k]    = 25'd0;
            strobe_d[k] = 1'b1;
          end else begin
            tmr_d[k] = tmr_q[k] + 25'd1;
          end
        end
        default: begin
          state_d[k] = ST_IDLE;
          tmr_d[k]   = 25'd0;
        end
      endcase
    end
  end

  // Apply the highest-priority strobe; lower-priority strobes in the same cycle are dropped.
  always_comb begin
    freq_d   = freq_q;
    amp_d    = amp_q;
    phase_d  = phase_q;
    en_d     = en_q;
    freq_sum = {1'b0, freq_q} + {1'b0, FREQ_STEP};
    if (strobe_q[0]) begin
      freq_d = freq_sum[12] ? 12'd4095 : freq_sum[11:0];
    end else if (strobe_q[1]) begin
      freq_d = (freq_q > FREQ_STEP) ? (freq_q - FREQ_STEP) : 12'd1;
    end else if (strobe_q[2]) begin
      amp_d = (amp_q >= 3'd7) ? 3'd1 : (amp_q + 3'd1);
    end else if (strobe_q[3]) begin
      phase_d = phase_q + PHASE_STEP;
    end else if (strobe_q[4]) begin
      en_d = {en_q[2:0], en_q[3]};
    end
    chg_d = (freq_d != freq_q) || (amp_d != amp_q) ||
            (phase_d != phase_q) || (en_d != en_q);
    param_upd_d = chg_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q      <= 5'b0;
      sync_q      <= 5'b0;
      acc_q       <= 5'b0;
      strobe_q    <= 5'b0;
      for (int k = 0; k < 5; k++) begin
        deb_cnt_q[k] <= 20'd0;
        state_q[k]   <= ST_IDLE;
        tmr_q[k]     <= 25'd0;
      end
      freq_q      <= FREQ_RESET;
      amp_q       <= 3'd1;
      phase_q     <= 8'd0;
      en_q        <= 4'b0001;
      chg_q       <= 1'b0;
      param_upd_q <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      acc_q       <= acc_d;
      strobe_q    <= strobe_d;
      for (int k = 0; k < 5; k++) begin
        deb_cnt_q[k] <= deb_cnt_d[k];
        state_q[k]   <= state_d[k];
        tmr_q[k]     <= tmr_d[k];
      end
      freq_q      <= freq_d;
      amp_q       <= amp_d;
      phase_q     <= phase_d;
      en_q        <= en_d;
      chg_q       <= chg_d;
      param_upd_q <= param_upd_d;
    end
  end

  assign state_freq  = freq_q;
  assign state_amp   = amp_q;
  assign state_phase = phase_q;
  assign en_sin      = en_q[0];
  assign en_sqr      = en_q[1];
  assign en_tri      = en_q[2];
  assign en_saw      = en_q[3];
  assign param_upd   = param_upd_q;

endmodule

// File: tb/tb_awg_param_ctrl.sv
// tb/tb_awg_param_ctrl.sv - directed self-checking bench for awg_param_ctrl
module tb_awg_param_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  key_n = 5'b11111;
  logic [11:0] state_freq;
  logic [2:0]  state_amp;
  logic [7:0]  state_phase;
  logic        en_sqr, en_sin, en_tri, en_saw;
  logic        param_upd;

  int checks = 0;
  int failures = 0;
  int upd_cnt = 0;

  awg_param_ctrl #(
    .DEB_CYCLES   (20'd4),
    .HOLD_CYCLES  (25'd20),
    .REPEAT_CYCLES(23'd5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .state_freq (state_freq),
    .state_amp  (state_amp),
    .state_phase(state_phase),
    .en_sqr     (en_sqr),
    .en_sin     (en_sin),
    .en_tri     (en_tri),
    .en_saw     (en_saw),
    .param_upd  (param_upd)
  );

  always #5 clk = ~clk;

  // Count param_upd pulses away from the active edge.
  always @(negedge clk) begin
    if (param_upd === 1'b1) upd_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  task automatic press(input int k, input int n);
    key_n[k] = 1'b0;
    run(n);
    key_n[k] = 1'b1;
    run(14);
  endtask

  logic [2:0] amp_exp [7];
  logic [3:0] en_exp [4];

  initial begin
    amp_exp = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
    en_exp  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset values
    run(1);
    do_reset();
    check_val("rst_freq", 32'(state_freq), 32'd64);
    check_val("rst_amp", 32'(state_amp), 32'd1);
    check_val("rst_phase", 32'(state_phase), 32'd0);
    check_val("rst_en", 32'({en_saw, en_tri, en_sqr, en_sin}), 32'b0001);
    check_val("rst_upd", 32'(param_upd), 32'd0);

    // Bounce rejection then a clean press with exact latency
    upd_cnt = 0;
    key_n[0] = 1'b0;
    run(3);
    key_n[0] = 1'b1;
    run(12);
    check_val("bounce_freq", 32'(state_freq), 32'd64);
    check_val("bounce_upd", 32'(upd_cnt), 32'd0);
    key_n[0] = 1'b0;
    run(7);
    check_val("lat_before", 32'(state_freq), 32'd64);
    run(1);
    check_val("lat_freq", 32'(state_freq), 32'd80);
    check_val("lat_upd_early", 32'(param_upd), 32'd0);
    run(1);
    check_val("lat_upd_pulse", 32'(param_upd), 32'd1);
    run(1);
    check_val("lat_upd_end", 32'(param_upd), 32'd0);
    key_n[0] = 1'b1;
    run(20);
    check_val("release_freq", 32'(state_freq), 32'd80);
    check_val("press_upd_cnt", 32'(upd_cnt), 32'd1);

    // Auto-repeat freq down from 64 with saturation at 1
    do_reset();
    upd_cnt = 0;
    key_n[1] = 1'b0;
    run(8);
    check_val("dn_first", 32'(state_freq), 32'd48);
    run(19);
    check_val("dn_hold", 32'(state_freq), 32'd48);
    run(1);
    check_val("dn_rep0", 32'(state_freq), 32'd32);
    run(5);
    check_val("dn_rep1", 32'(state_freq), 32'd16);
    run(5);
    check_val("dn_rep2", 32'(state_freq), 32'd1);
    run(22);
    key_n[1] = 1'b1;
    run(20);
    check_val("dn_sat", 32'(state_freq), 32'd1);
    check_val("dn_upd_cnt", 32'(upd_cnt), 32'd4);

    // Wrap behaviour of amp, phase and wave select
    for (int i = 0; i < 7; i++) begin
      press(2, 10);
      check_val($sformatf("amp_%0d", i), 32'(state_amp), 32'(amp_exp[i]));
    end
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] ph;
      ph = 8'(i * 16);
      press(3, 10);
      check_val($sformatf("phase_%0d", i), 32'(state_phase), 32'(ph));
    end
    for (int i = 0; i < 4; i++) begin
      press(4, 10);
      check_val($sformatf("wave_%0d", i), 32'({en_saw, en_tri, en_sqr, en_sin}), 32'(en_exp[i]));
    end

    // Simultaneous press: key0 beats key3
    do_reset();
    key_n = 5'b10110;
    run(10);
    key_n = 5'b11111;
    run(14);
    check_val("simul_freq", 32'(state_freq), 32'd80);
    check_val("simul_phase", 32'(state_phase), 32'd0);

    // Reset while key0 is auto-repeating
    do_reset();
    key_n[0] = 1'b0;
    run(35);
    check_val("midp_before", 32'(state_freq), 32'd112);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check_val("midp_rst_freq", 32'(state_freq), 32'd64);
    check_val("midp_rst_amp", 32'(state_amp), 32'd1);
    check_val("midp_rst_phase", 32'(state_phase), 32'd0);
    check_val("midp_rst_en", 32'({en_saw, en_tri, en_sqr, en_sin}), 32'b0001);
    check_val("midp_rst_upd", 32'(param_upd), 32'd0);
    upd_cnt = 0;
    run(7);
    check_val("midp_deb_wait", 32'(state_freq), 32'd64);
    run(1);
    check_val("midp_event", 32'(state_freq), 32'd80);
    run(2);
    key_n[0] = 1'b1;
    run(20);
    check_val("midp_final", 32'(state_freq), 32'd80);
    check_val("midp_upd_cnt", 32'(upd_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
